req_pending_ctrl: RTL and testbench
===================================

# req_pending_ctrl

Four-channel request capture and arbitration stage that sits directly upstream of the team's 4-to-2 priority encoding logic. It edge-detects four raw request lines, latches them as pending events, applies a per-channel mask, and presents the highest-priority eligible channel as a 2-bit code with valid/ready handshake. A pending bit is cleared only when its code is accepted downstream.

## Interface
- RST_MASK, 4'b1111, mask register value after reset (1 = channel enabled)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low
- req_in  input  4  raw level requests; event = 0→1 transition
- mask_we  input  1  write strobe for mask register
- mask_wdata  input  4  new mask value, taken when mask_we=1
- ovf_clr  input  1  pulse; clears all sticky overflow bits
- code  output  2  channel index presented (3 = highest priority)
- code_valid  output  1  code is valid and held stable
- code_ready  input  1  downstream accepts code when code_valid=1
- pending  output  4  latched, not-yet-accepted events (includes masked channels)
- mask  output  4  current mask register
- ovf  output  4  sticky: event arrived on a channel whose pending bit was already set

## Operation
- Edge detect: req_d register holds the previous sampled req_in; rise = req_s & ~req_d (req_s = req_in, or synchronized copy, see Configuration).
- pending[i]: set on rise[i]; cleared on handshake (code_valid & code_ready & code==i). Simultaneous clear and rise[i] → pending[i] stays 1, ovf[i] not set.
- ovf[i]: set when rise[i] and pending[i]=1 and no clear of i that cycle. ovf_clr clears all bits; set wins over simultaneous clear.
- eligible = pending & mask. Masked channels keep latching events and can overflow, but are never presented.
- FSM, two states:
  - IDLE: code_valid=0. If eligible≠0, load code = highest set index of eligible, go PRESENT.
  - PRESENT: code_valid=1, code frozen. On code_ready → clear pending[code], go IDLE. No preemption: a higher-priority arrival or a mask change does not alter or retract the presented code.
- Mask write is registered; it takes effect for arbitration on the cycle after mask_we.

## Timing
- Reset values: pending=0, ovf=0, mask=RST_MASK, code=0, code_valid=0, req_d=0, FSM=IDLE, sync flops=0.
- req_d resets to 0: a req_in level already high at reset release counts as one event.
- Latency (no sync): req_in first sampled high at edge N → pending set at N → code/code_valid registered at N+1 (visible after edge N+1).
- Handshake at edge M → pending cleared and FSM in IDLE at M; next code_valid no earlier than after edge M+1. One bubble cycle per grant; max throughput one code per 2 cycles.
- code_valid, once asserted, stays high with constant code until accepted; code_ready while code_valid=0 is ignored.
- Reset asserted mid-handshake: all state returns immediately to reset values; in-flight code is lost.

## Configuration
- REQ_SYNC_EN defined: req_in passes through a 2-flop synchronizer per bit before edge detection; req_in→code_valid latency grows by 2 cycles (edge N+3).
- Undefined: req_in used directly (must be synchronous to clk); latency as in Timing.

## Structure
- Package req_pkg: N_REQ=4, CODE_W=2, FSM state enum (ST_IDLE, ST_PRESENT).
- Sub-module priority_enc4: combinational, 4-bit in → 2-bit index (highest set bit wins) + any-valid flag; instantiated once on eligible.

## Test plan
- Single event: req_in 0000→0100 held → code=2, code_valid=1 two edges later; code_ready=1 → pending=0000, code_valid drops next cycle.
- Priority: rises on channels 0 and 3 in the same cycle → code=3 first; after accept, code=0 after one bubble cycle.
- No preemption: code=1 presented, code_ready=0, then rise on channel 3 → code stays 1 until accepted, then code=3.
- Mask: mask_wdata=0111 written, rise on channel 3 → pending=1000, code_valid stays 0; write mask=1111 → code=3 presented.
- Overflow: channel 2 pulsed twice before accept → ovf=0100; ovf_clr pulse → ovf=0000; rise coinciding with accept of channel 2 → pending[2] stays 1, ovf unchanged.
- Reset mid-operation: rst_n low while code_valid=1 → code_valid=0, pending=0, mask=RST_MASK immediately; req_in held high across release → one new event presented.

Source files
------------

// File: rtl/req_pkg.sv
// req_pkg: shared sizes, FSM state encoding and a small helper for the
// req_pending_ctrl request capture/arbitration slice.
package req_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // One-hot channel vector for a channel index, used to clear a pending bit.
  function automatic logic [N_REQ-1:0] code_onehot(input logic [CODE_W-1:0] idx);
    code_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/priority_enc4.sv
// priority_enc4: combinational 4-to-2 priority encoder, highest set bit wins.
//   vec_i  : request vector
//   idx_o  : index of the highest set bit (0 when vec_i is zero)
//   any_o  : at least one bit of vec_i is set
module priority_enc4
  import req_pkg::*;
(
  input  logic [N_REQ-1:0]  vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // Highest-index-first selection.
  always_comb begin
    idx_o = 2'd0;
    any_o = |vec_i;
    if (vec_i[3]) begin
      idx_o = 2'd3;
    end else if (vec_i[2]) begin
      idx_o = 2'd2;
    end else if (vec_i[1]) begin
      idx_o = 2'd1;
    end else begin
      idx_o = 2'd0;
    end
  end

endmodule

// File: rtl/req_pending_ctrl.sv
// req_pending_ctrl: edge-detects four raw request lines, latches the events
// as pending bits, masks them and presents the highest eligible channel as a
// 2-bit code with a valid/ready handshake. A pending bit clears only when its
// code is accepted.
//
// Optional build macro: REQ_SYNC_EN -- when defined, req_in passes through a
// 2-flop synchronizer per bit before edge detection (+2 cycles latency).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_in       : raw level requests, event = rising edge
//   mask_we      : mask register write strobe, mask_wdata = new value
//   ovf_clr      : pulse, clears all sticky overflow bits
//   code         : presented channel index (3 = highest priority)
//   code_valid   : code valid, held stable until accepted
//   code_ready   : downstream accept
//   pending      : latched, not-yet-accepted events (masked ones included)
//   mask         : current mask register (1 = channel enabled)
//   ovf          : sticky, event arrived while pending bit already set
module req_pending_ctrl
  import req_pkg::*;
#(
  parameter logic [N_REQ-1:0] RST_MASK = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_in,
  input  logic              mask_we,
  input  logic [N_REQ-1:0]  mask_wdata,
  input  logic              ovf_clr,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [N_REQ-1:0]  pending,
  output logic [N_REQ-1:0]  mask,
  output logic [N_REQ-1:0]  ovf
);

  logic [N_REQ-1:0]  req_s;
  logic [N_REQ-1:0]  req_d_q;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  ovf_q, ovf_d;
  logic [N_REQ-1:0]  mask_q, mask_d;
  logic [N_REQ-1:0]  rise_s, clr_s, ovf_set_s, eligible_s;
  logic              hs_s;
  logic [CODE_W-1:0] enc_idx_s;
  logic              enc_any_s;
  logic [CODE_W-1:0] code_q;
  logic              code_valid_q;
  state_e            state_q;

`ifdef REQ_SYNC_EN
  logic [N_REQ-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer on the raw request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= req_in;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_in;
`endif

  // Event, handshake and next-state logic for pending, overflow and mask.
  always_comb begin
    hs_s      = code_valid_q & code_ready;
    clr_s     = hs_s ? code_onehot(code_q) : 4'b0000;
    rise_s    = req_s & ~req_d_q;
    // A rise coinciding with the accept of the same channel re-arms it
    // without counting as overflow.
    pending_d = (pending_q & ~clr_s) | rise_s;
    ovf_set_s = rise_s & pending_q & ~clr_s;
    // Set wins over a simultaneous ovf_clr.
    if (ovf_clr) begin
      ovf_d = ovf_set_s;
    end else begin
      ovf_d = ovf_q | ovf_set_s;
    end
    if (mask_we) begin
      mask_d = mask_wdata;
    end else begin
      mask_d = mask_q;
    end
    eligible_s = pending_q & mask_q;
  end

  priority_enc4 u_enc (
    .vec_i (eligible_s),
    .idx_o (enc_idx_s),
    .any_o (enc_any_s)
  );

  // Edge-detect history plus pending, overflow and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d_q   <= 4'b0000;
      pending_q <= 4'b0000;
      ovf_q     <= 4'b0000;
      mask_q    <= RST_MASK;
    end else begin
      req_d_q   <= req_s;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      mask_q    <= mask_d;
    end
  end

  // Presentation FSM; once a code is presented it is frozen until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      code_q       <= 2'd0;
      code_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_any_s) begin
            code_q       <= enc_idx_s;
            code_valid_q <= 1'b1;
            state_q      <= ST_PRESENT;
          end else begin
            code_valid_q <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (code_ready) begin
            code_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            code_valid_q <= 1'b1;
          end
        end
        default: begin
          code_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_req_pending_ctrl.sv
module tb_req_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_in = 4'b0000;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = 4'b0000;
  logic       ovf_clr = 1'b0;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready = 1'b0;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel flags plus the presented grant.
  bit m_pend [4];
  bit m_ovf  [4];
  bit m_mask [4];
  bit m_prev [4];
  bit m_valid;
  int m_code;

  req_pending_ctrl #(.RST_MASK(4'b1111)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ovf_clr    (ovf_clr),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .mask       (mask),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pack(input bit a [4]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0; m_ovf[i] = 1'b0; m_mask[i] = 1'b1; m_prev[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_code  = 0;
  endtask

  // One rising edge of the specified behaviour, using pre-edge state.
  task automatic model_step();
    bit hs, rise, clr, any;
    bit np [4];
    int best;
    hs = m_valid && code_ready;
    for (int i = 0; i < 4; i++) begin
      rise  = req_in[i] && !m_prev[i];
      clr   = hs && (m_code == i);
      np[i] = (m_pend[i] && !clr) || rise;
      if (rise && m_pend[i] && !clr) m_ovf[i] = 1'b1;
      else if (ovf_clr) m_ovf[i] = 1'b0;
    end
    if (m_valid) begin
      if (code_ready) m_valid = 1'b0;
    end else begin
      any = 1'b0;
      best = 0;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && m_mask[i]) begin any = 1'b1; best = i; end
      if (any) begin m_valid = 1'b1; m_code = best; end
    end
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = np[i];
      m_prev[i] = req_in[i];
      if (mask_we) m_mask[i] = mask_wdata[i];
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("code_valid", {3'b000, code_valid}, {3'b000, m_valid});
    if (m_valid) chk("code", {2'b00, code}, m_code[3:0]);
    chk("pending", pending, pack(m_pend));
    chk("mask", mask, pack(m_mask));
    chk("ovf", ovf, pack(m_ovf));
  endtask

  // Advance one clock; strobes drop afterwards.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
    mask_we = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic step(input logic [3:0] r, input logic rdy);
    req_in = r;
    code_ready = rdy;
    cycle();
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", {3'b000, code_valid}, 4'b0000);
    chk("rst_code", {2'b00, code}, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_mask", mask, 4'b1111);
    chk("rst_ovf", ovf, 4'b0000);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single event on channel 2
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("single_code", {2'b00, code}, 4'b0010);
    chk("single_valid", {3'b000, code_valid}, 4'b0001);
    step(4'b0100, 1'b1);
    chk("single_cleared", pending, 4'b0000);
    step(4'b0000, 1'b0);

    // Priority: channels 0 and 3 together
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // No preemption
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    chk("nopreempt_code", {2'b00, code}, 4'b0001);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Mask blocks channel 3, then re-enabled
    mask_we = 1'b1; mask_wdata = 4'b0111;
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    chk("mask_pending", pending, 4'b1000);
    chk("mask_novalid", {3'b000, code_valid}, 4'b0000);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b0);

    // Overflow, clear, and rise coinciding with accept
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    chk("ovf_set", ovf, 4'b0100);
    ovf_clr = 1'b1;
    step(4'b0100, 1'b0);
    chk("ovf_cleared", ovf, 4'b0000);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b1);
    chk("accept_rise_pending", pending, 4'b0100);
    chk("accept_rise_ovf", ovf, 4'b0000);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Reset while a code is presented
    mask_we = 1'b1; mask_wdata = 4'b1011;
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", {3'b000, code_valid}, 4'b0000);
    chk("midrst_pending", pending, 4'b0000);
    chk("midrst_mask", mask, 4'b1111);
    step(4'b0001, 1'b1);
    rst_n = 1'b1;
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    chk("post_rst_code", {2'b00, code}, 4'b0000);
    chk("post_rst_valid", {3'b000, code_valid}, 4'b0001);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    chk("post_rst_single", {3'b000, code_valid}, 4'b0000);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        mask_we = 1'b1;
        mask_wdata = 4'($urandom_range(0, 15));
      end
      ovf_clr = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : req_in,
           $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
